// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Sweep sequencer for the dds_wave phase-accumulator core. It drives the
//   frequency word (k_out) from a start value towards a stop value in fixed
//   increments. Each value is held for a programmable dwell. Three run modes
//   are supported: single ramp, repeating sawtooth and continuous triangle.
//   The phase word (p_out) holds the configured offset for the whole run.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready   configuration handshake; accepted only in IDLE
//   cfg_k_start/stop/step sweep bounds and increment (KW bits)
//   cfg_dwell             cycles each K is held; 0 behaves as 1
//   cfg_mode              00 single, 01 sawtooth, 10 triangle, 11 single
//   cfg_phase             phase offset presented on p_out during a run
//   start, abort          run control; abort wins over everything
//   k_out, p_out          registered words to the DDS core
//   busy                  high while ramping up or down
//   done                  one-cycle pulse at the normal end of a single sweep
//   step_tick             one-cycle pulse on every K update inside a run
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [KW-1:0] cfg_k_start,
  input  logic [KW-1:0] cfg_k_stop,
  input  logic [KW-1:0] cfg_k_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  input  logic [PW-1:0] cfg_phase,
  input  logic          start,
  input  logic          abort,
  output logic [KW-1:0] k_out,
  output logic [PW-1:0] p_out,
  output logic          busy,
  output logic          done,
  output logic          step_tick
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_DOWN = 2'd2;

  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;

  logic [1:0]    state_q,     state_d;
  logic [KW-1:0] k_q,         k_d;
  logic [PW-1:0] p_q,         p_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic          tick_q,      tick_d;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;

  // Shadow configuration captured on the handshake.
  logic [KW-1:0] start_q, start_d;
  logic [KW-1:0] stop_q,  stop_d;
  logic [KW-1:0] step_q,  step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    mode_q,  mode_d;
  logic [PW-1:0] phase_q, phase_d;

  logic          cfg_fire;
  logic [KW-1:0] eff_start;
  logic [PW-1:0] eff_phase;
  logic [DW-1:0] dwell_eff;
  logic          dwell_end;
  logic          degenerate;
  logic          is_single;
  logic [KW:0]   up_sum;
  logic [KW:0]   start_sum;
  logic [KW:0]   down_diff;
  logic [KW-1:0] up_next;
  logic [KW-1:0] up_from_start;
  logic [KW-1:0] down_next;

  assign cfg_ready = (state_q == S_IDLE) & ~rst;
  assign cfg_fire  = cfg_valid & cfg_ready;

  // A start in the same cycle as a handshake uses the words being loaded.
  assign eff_start = cfg_fire ? cfg_k_start : start_q;
  assign eff_phase = cfg_fire ? cfg_phase   : phase_q;

  assign dwell_eff  = (dwell_q == '0) ? DW'(1) : dwell_q;
  assign dwell_end  = (dwell_cnt_q == dwell_eff - DW'(1));
  assign degenerate = (step_q == '0) || (start_q >= stop_q);
  assign is_single  = (mode_q != MODE_SAW) && (mode_q != MODE_TRI);

  // One extra bit on the sum/difference so a carry or borrow is seen as out of
  // range and clamps instead of wrapping around the K word.
  assign up_sum        = {1'b0, k_q} + {1'b0, step_q};
  assign start_sum     = {1'b0, start_q} + {1'b0, step_q};
  assign down_diff     = {1'b0, k_q} - {1'b0, step_q};
  assign up_next       = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[KW-1:0];
  assign up_from_start = (start_sum > {1'b0, stop_q}) ? stop_q : start_sum[KW-1:0];
  assign down_next     = (down_diff[KW] || (down_diff[KW-1:0] < start_q)) ?
                         start_q : down_diff[KW-1:0];

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    p_d         = p_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tick_d      = 1'b0;
    dwell_cnt_d = dwell_cnt_q;
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    mode_d      = mode_q;
    phase_d     = phase_q;

    if (cfg_fire) begin
      start_d = cfg_k_start;
      stop_d  = cfg_k_stop;
      step_d  = cfg_k_step;
      dwell_d = cfg_dwell;
      mode_d  = cfg_mode;
      phase_d = cfg_phase;
    end

    if (abort) begin
      state_d = S_IDLE;
      k_d     = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            k_d         = eff_start;
            p_d         = eff_phase;
            dwell_cnt_d = '0;
            busy_d      = 1'b1;
            state_d     = S_UP;
          end
        end
        S_UP: begin
          if (!dwell_end) begin
            dwell_cnt_d = dwell_cnt_q + DW'(1);
          end else begin
            dwell_cnt_d = '0;
            if (degenerate || ((k_q == stop_q) && is_single)) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (k_q != stop_q) begin
              k_d    = up_next;
              tick_d = 1'b1;
            end else if (mode_q == MODE_SAW) begin
              k_d    = start_q;
              tick_d = 1'b1;
            end else begin
              k_d     = down_next;
              state_d = S_DOWN;
              tick_d  = 1'b1;
            end
          end
        end
        S_DOWN: begin
          if (!dwell_end) begin
            dwell_cnt_d = dwell_cnt_q + DW'(1);
          end else begin
            dwell_cnt_d = '0;
            tick_d      = 1'b1;
            if (k_q != start_q) begin
              k_d = down_next;
            end else begin
              k_d     = up_from_start;
              state_d = S_UP;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      p_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_q      <= 1'b0;
      dwell_cnt_q <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      mode_q      <= '0;
      phase_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      p_q         <= p_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tick_q      <= tick_d;
      dwell_cnt_q <= dwell_cnt_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      mode_q      <= mode_d;
      phase_q     <= phase_d;
    end
  end

  assign k_out     = k_q;
  assign p_out     = p_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_tick = tick_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Self-checking bench for dds_sweep_ctrl. Each run builds the list of K values
//   the sweep should visit (plain 64-bit arithmetic), expands it by the dwell
//   and compares every cycle against the DUT. Directed runs cover the documented
//   scenarios; randomized runs follow.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

  localparam int KW = 32;
  localparam int PW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [KW-1:0] cfg_k_start, cfg_k_stop, cfg_k_step;
  logic [DW-1:0] cfg_dwell;
  logic [1:0]    cfg_mode;
  logic [PW-1:0] cfg_phase;
  logic          start, abort;
  logic [KW-1:0] k_out;
  logic [PW-1:0] p_out;
  logic          busy, done, step_tick;

  int n_pass  = 0;
  int n_total = 0;

  longint seq[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.KW(KW), .PW(PW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_k_start (cfg_k_start),
    .cfg_k_stop  (cfg_k_stop),
    .cfg_k_step  (cfg_k_step),
    .cfg_dwell   (cfg_dwell),
    .cfg_mode    (cfg_mode),
    .cfg_phase   (cfg_phase),
    .start       (start),
    .abort       (abort),
    .k_out       (k_out),
    .p_out       (p_out),
    .busy        (busy),
    .done        (done),
    .step_tick   (step_tick)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic junk_cfg();
    cfg_k_start = $urandom;
    cfg_k_stop  = $urandom;
    cfg_k_step  = $urandom;
    cfg_dwell   = DW'($urandom);
    cfg_mode    = 2'($urandom);
    cfg_phase   = PW'($urandom);
  endtask

  // One period of K values. Single/sawtooth: start up to stop (clamped).
  // Triangle: that ramp followed by the descent, excluding the final start
  // which begins the next period. Degenerate configs visit only start.
  task automatic build_period(input longint s, input longint e, input longint stp,
                              input bit tri_mode);
    longint v;
    seq.delete();
    if (stp == 0 || s >= e) begin
      seq.push_back(s);
    end else begin
      v = s;
      seq.push_back(v);
      while (v != e) begin
        v = (v + stp > e) ? e : v + stp;
        seq.push_back(v);
      end
      if (tri_mode) begin
        v = e;
        while (1) begin
          v = (v - stp < s) ? s : v - stp;
          if (v == s) break;
          seq.push_back(v);
        end
      end
    end
  endtask

  task automatic run_sweep(input logic [KW-1:0] s, input logic [KW-1:0] e,
                           input logic [KW-1:0] stp, input logic [DW-1:0] dw,
                           input logic [1:0] md, input logic [PW-1:0] ph,
                           input bit same_cycle, input int n_per);
    int     de, total, idx;
    bit     periodic, ab;
    longint last;
    de       = (dw == '0) ? 1 : int'(dw);
    periodic = (md == 2'b01 || md == 2'b10) && !(stp == '0 || s >= e);
    build_period(s, e, stp, md == 2'b10);
    total    = periodic ? n_per : seq.size() * de;
    last     = seq[seq.size()-1];

    @(negedge clk);
    check("cfg_ready_idle", 64'(cfg_ready), 64'(1));
    cfg_k_start = s; cfg_k_stop = e; cfg_k_step = stp;
    cfg_dwell = dw; cfg_mode = md; cfg_phase = ph;
    cfg_valid = 1'b1;
    start     = same_cycle;
    if (!same_cycle) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      junk_cfg();
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0; cfg_valid = 1'b0;
    junk_cfg();

    for (int c = 0; c < total; c++) begin
      idx = (c / de) % seq.size();
      check("k_run",     64'(k_out),     64'(seq[idx]));
      check("p_run",     64'(p_out),     64'(ph));
      check("busy_run",  64'(busy),      64'(1));
      check("done_run",  64'(done),      64'(0));
      check("tick_run",  64'(step_tick), 64'((c % de == 0) && (c > 0)));
      check("ready_run", 64'(cfg_ready), 64'(0));
      // Start and config traffic while busy must be ignored.
      start     = ($urandom_range(0, 3) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      junk_cfg();
      if (c == total - 1) begin
        cfg_valid = 1'b0;
        if (periodic) abort = 1'b1;
      end
      @(negedge clk);
    end

    if (periodic) begin
      check("k_abort",     64'(k_out),     64'(0));
      check("busy_abort",  64'(busy),      64'(0));
      check("done_abort",  64'(done),      64'(0));
      check("tick_abort",  64'(step_tick), 64'(0));
      check("ready_abort", 64'(cfg_ready), 64'(1));
      abort = 1'b0; start = 1'b0;
      @(negedge clk);
      check("k_after_abort", 64'(k_out), 64'(0));
      check("done_after_abort", 64'(done), 64'(0));
    end else begin
      check("k_end",     64'(k_out),     64'(last));
      check("p_end",     64'(p_out),     64'(ph));
      check("busy_end",  64'(busy),      64'(0));
      check("done_end",  64'(done),      64'(1));
      check("tick_end",  64'(step_tick), 64'(0));
      check("ready_end", 64'(cfg_ready), 64'(1));
      start = 1'b0;
      ab    = 1'($urandom_range(0, 1));
      abort = ab;
      @(negedge clk);
      abort = 1'b0;
      check("k_hold", 64'(k_out), ab ? 64'(0) : 64'(last));
      check("done_once", 64'(done), 64'(0));
      check("busy_idle", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    logic [KW-1:0] s, e, stp;
    int            r;
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    junk_cfg();
    repeat (2) @(negedge clk);
    check("rst_k",     64'(k_out),     64'(0));
    check("rst_p",     64'(p_out),     64'(0));
    check("rst_busy",  64'(busy),      64'(0));
    check("rst_done",  64'(done),      64'(0));
    check("rst_tick",  64'(step_tick), 64'(0));
    check("rst_ready", 64'(cfg_ready), 64'(0));
    rst = 1'b0;

    // Documented scenarios.
    run_sweep(32'd100, 32'd130, 32'd10, 16'd3, 2'b00, 11'h123, 1'b0, 0);
    run_sweep(32'd0,   32'd25,  32'd10, 16'd1, 2'b00, 11'h005, 1'b0, 0);
    run_sweep(32'd5,   32'd8,   32'd2,  16'd2, 2'b10, 11'h2AA, 1'b0, 40);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd2, 2'b00, 11'h000, 1'b1, 0);
    run_sweep(32'd100, 32'd130, 32'd10, 16'd0, 2'b00, 11'h044, 1'b1, 0);
    run_sweep(32'd50,  32'd90,  32'd0,  16'd4, 2'b10, 11'h3FF, 1'b0, 0);
    run_sweep(32'd60,  32'd60,  32'd5,  16'd2, 2'b01, 11'h011, 1'b1, 0);
    run_sweep(32'd10,  32'd40,  32'd7,  16'd1, 2'b01, 11'h077, 1'b1, 30);
    run_sweep(32'd3,   32'd10,  32'hFFFF_0000, 16'd1, 2'b10, 11'h100, 1'b0, 12);

    // Randomized runs.
    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      s = $urandom_range(0, 32'hFFFF_0000);
      case (r)
        0:       e = s - $urandom_range(1, 100);
        1:       e = s;
        2: begin e = 32'hFFFF_FFFF; s = e - $urandom_range(1, 100); end
        default: e = s + $urandom_range(1, 150);
      endcase
      r = $urandom_range(0, 9);
      if (r == 0)      stp = '0;
      else if (r == 1) stp = $urandom;
      else             stp = $urandom_range(1, 40);
      run_sweep(s, e, stp, DW'($urandom_range(0, 4)), 2'($urandom),
                PW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(10, 120));
    end

    // Reset in the middle of a triangle run.
    @(negedge clk);
    cfg_k_start = 32'd5; cfg_k_stop = 32'd8; cfg_k_step = 32'd2;
    cfg_dwell = 16'd2; cfg_mode = 2'b10; cfg_phase = 11'h155;
    cfg_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_pre_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_k",     64'(k_out),     64'(0));
    check("mid_rst_p",     64'(p_out),     64'(0));
    check("mid_rst_busy",  64'(busy),      64'(0));
    check("mid_rst_done",  64'(done),      64'(0));
    check("mid_rst_tick",  64'(step_tick), 64'(0));
    check("mid_rst_ready", 64'(cfg_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(cfg_ready), 64'(1));
    check("post_rst_busy",  64'(busy),      64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
